// File: rtl/sdram_bridge_pkg.sv
// rtl/sdram_bridge_pkg.sv - shared types and constants for the sample-to-SDRAM bridge
package sdram_bridge_pkg;

    localparam int ADDR_W_DEFAULT = 25;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Active-low byte enables selecting one 16-bit half of the 32-bit SDRAM word
    localparam logic [3:0] BE_LO   = 4'b1100;
    localparam logic [3:0] BE_HI   = 4'b0011;
    localparam logic [3:0] BE_NONE = 4'b1111;

endpackage

// File: rtl/sdram_sample_bridge_if.sv
// rtl/sdram_sample_bridge_if.sv - core sample port and Avalon-MM SDRAM signals of the bridge
interface sdram_sample_bridge_if
    import sdram_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_done;
    logic              mem_err;
    logic              busy;

    logic [ADDR_W-1:0] sdram_address;
    logic [3:0]        sdram_byteenable_n;
    logic              sdram_chipselect;
    logic [31:0]       sdram_writedata;
    logic              sdram_read_n;
    logic              sdram_write_n;
    logic [31:0]       sdram_readdata;
    logic              sdram_readdatavalid;
    logic              sdram_waitrequest;

    modport master (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_done, mem_err, busy,
        output sdram_address, sdram_byteenable_n, sdram_chipselect, sdram_writedata,
        output sdram_read_n, sdram_write_n,
        input  sdram_readdata, sdram_readdatavalid, sdram_waitrequest
    );

    modport slave (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_done, mem_err, busy,
        input  sdram_address, sdram_byteenable_n, sdram_chipselect, sdram_writedata,
        input  sdram_read_n, sdram_write_n,
        output sdram_readdata, sdram_readdatavalid, sdram_waitrequest
    );

endinterface

// File: rtl/sdram_sample_bridge.sv
// rtl/sdram_sample_bridge.sv - single-sample read/write bridge onto a 32-bit Avalon-MM SDRAM slave
module sdram_sample_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [31:0]       i_mem_addr,
    input  logic [15:0]       i_mem_wdata,
    output logic [15:0]       o_mem_rdata,
    output logic              o_mem_done,
    output logic              o_mem_err,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_sdram_address,
    output logic [3:0]        o_sdram_byteenable_n,
    output logic              o_sdram_chipselect,
    output logic [31:0]       o_sdram_writedata,
    output logic              o_sdram_read_n,
    output logic              o_sdram_write_n,
    input  logic [31:0]       i_sdram_readdata,
    input  logic              i_sdram_readdatavalid,
    input  logic              i_sdram_waitrequest
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    state_t            r_state;
    logic              r_half;
    logic [CNT_W-1:0]  r_cnt;
    logic [15:0]       r_rdata;
    logic              r_done;
    logic              r_err;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be_n;
    logic [31:0]       r_wdata;
    logic              r_cs;
    logic              r_rd_n;
    logic              r_wr_n;

    logic [ADDR_W-1:0] w_word;
    logic [3:0]        w_be_n;
    logic              w_unused_addr;

    // Sample address bit 0 picks the half-word; bits above the word field wrap away
    assign w_word        = i_mem_addr[ADDR_W:1];
    assign w_be_n        = i_mem_addr[0] ? BE_HI : BE_LO;
    assign w_unused_addr = ^i_mem_addr[31:ADDR_W+1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_half  <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= 16'h0000;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_be_n  <= BE_NONE;
            r_wdata <= 32'h0;
            r_cs    <= 1'b0;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_mem_write) begin
                        r_state <= WR_REQ;
                        r_half  <= i_mem_addr[0];
                        r_addr  <= w_word;
                        r_be_n  <= w_be_n;
                        r_wdata <= {i_mem_wdata, i_mem_wdata};
                        r_cs    <= 1'b1;
                        r_wr_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (i_mem_read) begin
                        r_state <= RD_REQ;
                        r_half  <= i_mem_addr[0];
                        r_addr  <= w_word;
                        r_be_n  <= w_be_n;
                        r_cs    <= 1'b1;
                        r_rd_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (!i_sdram_waitrequest) begin
                        r_state <= DONE;
                        r_cs    <= 1'b0;
                        r_wr_n  <= 1'b1;
                        r_be_n  <= BE_NONE;
                        r_err   <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (!i_sdram_waitrequest) begin
                        r_state <= RD_WAIT;
                        r_cs    <= 1'b0;
                        r_rd_n  <= 1'b1;
                        r_be_n  <= BE_NONE;
                        r_cnt   <= '0;
                    end
                end
                RD_WAIT: begin
                    if (i_sdram_readdatavalid) begin
                        r_state <= DONE;
                        r_rdata <= r_half ? i_sdram_readdata[31:16] : i_sdram_readdata[15:0];
                        r_err   <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                        r_state <= DONE;
                        r_rdata <= 16'h0000;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cs    <= 1'b0;
                    r_rd_n  <= 1'b1;
                    r_wr_n  <= 1'b1;
                    r_be_n  <= BE_NONE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_rdata          = r_rdata;
    assign o_mem_done           = r_done;
    assign o_mem_err            = r_err;
    assign o_busy               = r_busy;
    assign o_sdram_address      = r_addr;
    assign o_sdram_byteenable_n = r_be_n;
    assign o_sdram_chipselect   = r_cs;
    assign o_sdram_writedata    = r_wdata;
    assign o_sdram_read_n       = r_rd_n;
    assign o_sdram_write_n      = r_wr_n;

endmodule

// File: tb/tb_sdram_sample_bridge.sv
// tb/tb_sdram_sample_bridge.sv - scoreboard bench for sdram_sample_bridge with an SDRAM slave model
module tb_sdram_sample_bridge;

    localparam int AW = 25;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_sample_bridge_if #(.ADDR_W(AW)) bus ();

    sdram_sample_bridge #(.ADDR_W(AW), .RD_TIMEOUT(TO)) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_mem_read            (bus.mem_read),
        .i_mem_write           (bus.mem_write),
        .i_mem_addr            (bus.mem_addr),
        .i_mem_wdata           (bus.mem_wdata),
        .o_mem_rdata           (bus.mem_rdata),
        .o_mem_done            (bus.mem_done),
        .o_mem_err             (bus.mem_err),
        .o_busy                (bus.busy),
        .o_sdram_address       (bus.sdram_address),
        .o_sdram_byteenable_n  (bus.sdram_byteenable_n),
        .o_sdram_chipselect    (bus.sdram_chipselect),
        .o_sdram_writedata     (bus.sdram_writedata),
        .o_sdram_read_n        (bus.sdram_read_n),
        .o_sdram_write_n       (bus.sdram_write_n),
        .i_sdram_readdata      (bus.sdram_readdata),
        .i_sdram_readdatavalid (bus.sdram_readdatavalid),
        .i_sdram_waitrequest   (bus.sdram_waitrequest)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [3:0]  be_n;
        logic [31:0] wd;
    } beat_t;

    typedef struct {
        logic [15:0] rd;
        bit          err;
        int          cyc;
    } resp_t;

    beat_t       q_beat[$];
    resp_t       q_resp[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] hold_rdata = 16'h0;
    logic [15:0] last_rd = 16'h0;
    int          cfg_wait = 0;
    int          cfg_lat = 1;
    logic [15:0] model[longint];
    logic [31:0] sdram[longint];

    function automatic logic [15:0] sample_init(longint sa);
        return 16'((sa * 40503) ^ 16'h1234);
    endfunction

    function automatic logic [31:0] word_init(longint w);
        return {sample_init(2 * w + 1), sample_init(2 * w)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SDRAM slave: random waitrequest stretch, configurable read latency, stray readdatavalid
    initial begin
        bit          prev_act = 1'b0;
        bit          prev_wr = 1'b0;
        logic [31:0] prev_addr = 32'h0;
        logic [3:0]  prev_be = 4'hF;
        logic [31:0] prev_wd = 32'h0;
        int          wait_left = 0;
        bit          rd_pend = 1'b0;
        int          rd_cnt = 0;
        logic [31:0] rd_word = 32'h0;
        bit          act;
        beat_t       e;
        bus.sdram_waitrequest   = 1'b0;
        bus.sdram_readdatavalid = 1'b0;
        bus.sdram_readdata      = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_act && !bus.sdram_waitrequest && rst_n) begin
                if (q_beat.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got unexpected Avalon beat addr %h expected none", prev_addr);
                end else begin
                    e = q_beat.pop_front();
                    chk("beat_kind", 32'(prev_wr), 32'(e.is_wr));
                    chk("beat_addr", prev_addr, e.addr);
                    chk("beat_be_n", 32'(prev_be), 32'(e.be_n));
                    if (e.is_wr) chk("beat_wdata", prev_wd, e.wd);
                end
                if (prev_wr) begin
                    logic [31:0] w;
                    w = sdram.exists(prev_addr) ? sdram[prev_addr] : word_init(prev_addr);
                    for (int i = 0; i < 4; i++)
                        if (!prev_be[i]) w[8*i +: 8] = prev_wd[8*i +: 8];
                    sdram[prev_addr] = w;
                end else begin
                    rd_pend = (cfg_lat > 0);
                    rd_cnt  = cfg_lat;
                    rd_word = sdram.exists(prev_addr) ? sdram[prev_addr] : word_init(prev_addr);
                end
            end
            act = bus.sdram_chipselect && (!bus.sdram_read_n || !bus.sdram_write_n);
            if (rd_pend && rd_cnt == 1) begin
                bus.sdram_readdatavalid = 1'b1;
                bus.sdram_readdata      = rd_word;
                rd_pend                 = 1'b0;
            end else begin
                if (rd_pend) rd_cnt--;
                bus.sdram_readdatavalid = act && ($urandom_range(0, 3) == 0);
                bus.sdram_readdata      = $urandom;
            end
            if (act) begin
                if (!prev_act) wait_left = cfg_wait;
                bus.sdram_waitrequest = (wait_left > 0);
                if (wait_left > 0) wait_left--;
            end else begin
                bus.sdram_waitrequest = 1'($urandom_range(0, 1));
            end
            prev_act  = act;
            prev_wr   = !bus.sdram_write_n;
            prev_addr = 32'(bus.sdram_address);
            prev_be   = bus.sdram_byteenable_n;
            prev_wd   = bus.sdram_writedata;
        end
    end

    // Completion monitor
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (bus.mem_done) begin
                if (q_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_done: got done pulse expected none (cycle %0d)", cyc);
                end else begin
                    r = q_resp.pop_front();
                    chk("done_rdata", 32'(bus.mem_rdata), 32'(r.rd));
                    chk("done_err", 32'(bus.mem_err), 32'(r.err));
                    chk("done_cycle", cyc, r.cyc);
                    hold_rdata = r.rd;
                end
            end else begin
                chk("rdata_hold", 32'(bus.mem_rdata), 32'(hold_rdata));
            end
            if (!bus.busy)
                chk("idle_strobes",
                    {25'h0, bus.sdram_chipselect, bus.sdram_read_n, bus.sdram_write_n, bus.sdram_byteenable_n},
                    {25'h0, 1'b0, 1'b1, 1'b1, 4'hF});
        end
    end

    task automatic wait_done();
        int i;
        i = 0;
        while (q_resp.size() != 0 && i < 60) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (q_resp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles expected one", i);
            q_resp.delete();
        end
        chk("beats_left", q_beat.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // lat = 0 means the slave never returns read data
    task automatic issue(bit rd, bit wr, logic [31:0] addr, logic [15:0] wd, int w, int lat, bit junk);
        longint sa;
        beat_t  b;
        resp_t  r;
        int     rc;
        sa = longint'(addr) % (64'd1 << (AW + 1));
        rc = cyc;
        cfg_wait = w;
        cfg_lat  = lat;
        b.is_wr = wr;
        b.addr  = 32'(sa / 2);
        b.be_n  = (sa % 2 == 1) ? 4'b0011 : 4'b1100;
        b.wd    = {wd, wd};
        q_beat.push_back(b);
        if (wr) begin
            model[sa] = wd;
            r = '{rd: last_rd, err: 1'b0, cyc: rc + 2 + w};
        end else if (lat > 0) begin
            last_rd = model.exists(sa) ? model[sa] : sample_init(sa);
            r = '{rd: last_rd, err: 1'b0, cyc: rc + 2 + w + lat};
        end else begin
            last_rd = 16'h0;
            r = '{rd: 16'h0, err: 1'b1, cyc: rc + 2 + w + TO};
        end
        q_resp.push_back(r);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        @(posedge clk);
        #1;
        for (int i = 0; i <= w; i++) begin
            bus.mem_read  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_write = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_addr  = $urandom;
            bus.mem_wdata = 16'($urandom);
            @(posedge clk);
            #1;
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        wait_done();
    endtask

    task automatic check_reset_values();
        chk("rst_done", 32'(bus.mem_done), 32'h0);
        chk("rst_err", 32'(bus.mem_err), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_rdata", 32'(bus.mem_rdata), 32'h0);
        chk("rst_cs", 32'(bus.sdram_chipselect), 32'h0);
        chk("rst_read_n", 32'(bus.sdram_read_n), 32'h1);
        chk("rst_write_n", 32'(bus.sdram_write_n), 32'h1);
        chk("rst_be_n", 32'(bus.sdram_byteenable_n), 32'hF);
        chk("rst_address", 32'(bus.sdram_address), 32'h0);
        chk("rst_writedata", bus.sdram_writedata, 32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no end of test expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 16'h0;
        repeat (3) @(negedge clk);
        #2;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b0, 1'b1, 32'h5, 16'hBEEF, 0, 0, 1'b0);
        sdram[2] = 32'h1234ABCD;
        model[4] = 16'hABCD;
        model[5] = 16'h1234;
        issue(1'b1, 1'b0, 32'h4, 16'h0, 3, 2, 1'b0);
        issue(1'b1, 1'b0, 32'h7, 16'h0, 0, 0, 1'b0);
        issue(1'b1, 1'b1, 32'h9, 16'h55AA, 2, 0, 1'b1);
        issue(1'b1, 1'b0, 32'h9, 16'h0, 0, 1, 1'b1);
        issue(1'b0, 1'b1, 32'h0400_0001, 16'hC0DE, 0, 0, 1'b0);
        issue(1'b1, 1'b0, 32'h1, 16'h0, 1, 3, 1'b0);
        issue(1'b1, 1'b0, 32'h0, 16'h0, 0, 1, 1'b0);

        for (int n = 0; n < 48; n++) begin
            logic [31:0] a;
            int          kind;
            a    = $urandom_range(0, 31);
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 4) == 0) a = a | ($urandom << 26);
            if (kind < 4)
                issue(1'b0, 1'b1, a, 16'($urandom), $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)));
            else if (kind < 8)
                issue(1'b1, 1'b0, a, 16'h0, $urandom_range(0, 3), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
            else if (kind == 8)
                issue(1'b1, 1'b1, a, 16'($urandom), $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)));
            else
                issue(1'b1, 1'b0, a, 16'h0, $urandom_range(0, 2), 0, 1'b0);
        end

        // Reset during RD_WAIT; the late read data must not complete anything
        begin
            beat_t b;
            cfg_wait = 0;
            cfg_lat  = 6;
            b = '{is_wr: 1'b0, addr: 32'h1, be_n: 4'b0011, wd: 32'h0};
            q_beat.push_back(b);
            bus.mem_read = 1'b1;
            bus.mem_addr = 32'h3;
            @(posedge clk);
            #1;
            bus.mem_read = 1'b0;
            repeat (2) @(posedge clk);
            chk("pre_reset_busy", 32'(bus.busy), 32'h1);
            @(negedge clk);
            #2;
            rst_n      = 1'b0;
            hold_rdata = 16'h0;
            last_rd    = 16'h0;
            #1;
            check_reset_values();
            @(negedge clk);
            rst_n = 1'b1;
            repeat (12) @(posedge clk);
            #1;
            chk("post_reset_busy", 32'(bus.busy), 32'h0);
            chk("post_reset_rdata", 32'(bus.mem_rdata), 32'h0);
            chk("post_reset_beats", q_beat.size(), 0);
        end
        issue(1'b1, 1'b0, 32'h4, 16'h0, 0, 2, 1'b0);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
